// File: rtl/rca_wide_add_sequencer_if.sv
// Operand/result stream bundle for the wide-add sequencer.
// A transfer on either channel happens on a rising clk edge where valid and ready are both high;
// a producer holds valid and its data stable until that edge, and ready may be asserted regardless of valid.
interface rca_wide_add_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
);
  localparam int OW = WIDTH * WORDS;

  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_a;
  logic [OW-1:0] in_b;
  logic          in_cin;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_sum;
  logic          out_cout;
  logic          out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/rca_wide_add_sequencer.sv
// Multi-precision add controller: walks WORDS slices through an external WIDTH-bit
// ripple-carry adder, LSB slice first, chaining the carry through carry_q.
module rca_wide_add_sequencer #(
  parameter int WIDTH         = 16,
  parameter int WORDS         = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rca_wide_add_sequencer_if.slave bus,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout,
  output logic                 busy,
  output logic [1:0]           dbg_state
);
  localparam int OW    = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [OW-1:0]     a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  add_a_q, add_a_d, add_b_q, add_b_d;
  logic              add_cin_q, add_cin_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    add_a_d   = '0;
    add_b_d   = '0;
    add_cin_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST_CNT) begin
          sum_d[idx_q*WIDTH +: WIDTH] = add_sum;
          carry_d = add_cout;
          cnt_d   = '0;
          if (idx_q == LAST_IDX) begin
            // Signed overflow: like-signed operands producing a result of the other sign.
            cout_d  = add_cout;
            ovf_d   = (a_q[OW-1] == b_q[OW-1]) && (add_sum[WIDTH-1] != a_q[OW-1]);
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Adder inputs are registered from next-state values so they change only on a clock edge.
    if (state_d == RUN) begin
      add_a_d   = a_d[idx_d*WIDTH +: WIDTH];
      add_b_d   = b_d[idx_d*WIDTH +: WIDTH];
      add_cin_d = carry_d;
    end
  end

  assign add_a         = add_a_q;
  assign add_b         = add_b_q;
  assign add_cin       = add_cin_q;
  assign busy          = (state_q == RUN);
  assign dbg_state     = state_q;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_rca_wide_add_sequencer.sv
// Bench for rca_wide_add_sequencer: behavioural 16-bit adder on the add_* port, arithmetic
// reference model for the wide sum, and a scoreboard queue of expected {ovf, cout, sum}.
module tb_rca_wide_add_sequencer;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int ST = 2;
  localparam int OW = W * N;
  localparam int LAT = N * ST;

  logic clk;
  logic rst_n;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout, busy;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW+1:0] exp_q[$];

  rca_wide_add_sequencer_if #(.WIDTH(W), .WORDS(N)) bus ();

  rca_wide_add_sequencer #(.WIDTH(W), .WORDS(N), .SETTLE_CYCLES(ST)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .busy(busy), .dbg_state(dbg_state)
  );

  // Stand-in for rc_adder16.
  logic [W:0] slice_full;
  assign slice_full = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
  assign add_sum    = slice_full[W-1:0];
  assign add_cout   = slice_full[W];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [OW+1:0] model(input logic [OW-1:0] a, input logic [OW-1:0] b,
                                          input logic cin);
    logic [OW:0] full;
    logic        ovf;
    full = {1'b0, a} + {1'b0, b} + {{OW{1'b0}}, cin};
    ovf  = (a[OW-1] == b[OW-1]) && (full[OW-1] != a[OW-1]);
    return {ovf, full[OW], full[OW-1:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_result(output int lat, output int busy_cnt, output logic [N-1:0] cins);
    int n;
    n = 0; busy_cnt = 0; cins = '0;
    while (!bus.out_valid && n < 40) begin
      if (busy) begin
        busy_cnt++;
        if (n / ST < N) cins[n / ST] = add_cin;
      end
      @(posedge clk); @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  task automatic run_op(input logic [OW-1:0] a, input logic [OW-1:0] b, input logic cin,
                        output int lat, output int busy_cnt, output logic [N-1:0] cins,
                        output logic [OW+1:0] got);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.in_ready && guard < 40) begin
      @(negedge clk); guard++;
    end
    bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_cin = cin;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0; bus.in_a = $urandom; bus.in_b = $urandom; bus.in_cin = 1'b0;
    wait_result(lat, busy_cnt, cins);
    got = {bus.out_ovf, bus.out_cout, bus.out_sum};
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cout=%b ovf=%b busy=%b want all 0",
               bus.out_valid, bus.out_sum, bus.out_cout, bus.out_ovf, busy);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if ({add_a, add_b, add_cin} !== '0 || bus.in_ready !== 1'b1 || dbg_state !== 2'd0) begin
        n_fail++;
        $display("FAIL idle_adder_inputs: got a=%h b=%h cin=%b rdy=%b st=%0d want 0 0 0 1 0",
                 add_a, add_b, add_cin, bus.in_ready, dbg_state);
      end
    end
  endtask

  task automatic check_op(input string name, input logic [OW-1:0] a, input logic [OW-1:0] b,
                          input logic cin, input logic check_cins, input logic [N-1:0] exp_cins);
    int lat, bcnt;
    logic [N-1:0]  cins;
    logic [OW+1:0] got, exp;
    exp_q.push_back(model(a, b, cin));
    run_op(a, b, cin, lat, bcnt, cins, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s_result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h", name,
               got[OW+1], got[OW], got[OW-1:0], exp[OW+1], exp[OW], exp[OW-1:0]);
    end
    n_checks++;
    if (lat !== LAT || bcnt !== LAT) begin
      n_fail++;
      $display("FAIL %s_latency: got lat=%0d busy=%0d want %0d %0d", name, lat, bcnt, LAT, LAT);
    end
    if (check_cins) begin
      n_checks++;
      if (cins !== exp_cins) begin
        n_fail++; $display("FAIL %s_slice_cin: got %b want %b", name, cins, exp_cins);
      end
    end
  endtask

  task automatic test_carry_chain;
    check_op("carry_chain", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b1, 4'b0010);
    check_op("all_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b1, 4'b1111);
  endtask

  task automatic test_overflow;
    check_op("pos_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, '0);
    check_op("neg_ovf", 64'hBFFF_FFFF_FFFF_FFFF, 64'hBFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, '0);
  endtask

  task automatic test_random;
    logic [OW-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 4 == 1) b = ~a;
      if (i % 4 == 2) a[OW-1:OW-2] = 2'b01;
      check_op("random", a, b, 1'($urandom_range(0, 1)), 1'b0, '0);
    end
  endtask

  task automatic test_backpressure;
    int lat, bcnt;
    logic [N-1:0]  cins;
    logic [OW-1:0] a1, b1, a2, b2;
    logic [OW+1:0] exp1, exp2, got;
    a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
    exp_q.push_back(model(a1, b1, 1'b1));
    exp_q.push_back(model(a2, b2, 1'b0));
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = a1; bus.in_b = b1; bus.in_cin = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result(lat, bcnt, cins);
    exp1 = exp_q.pop_front();
    bus.in_valid = 1'b1; bus.in_a = a2; bus.in_b = b2; bus.in_cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      got = {bus.out_ovf, bus.out_cout, bus.out_sum};
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || busy !== 1'b0 || got !== exp1) begin
        n_fail++;
        $display("FAIL bp_hold: got valid=%b rdy=%b busy=%b res=%h want 1 0 0 %h",
                 bus.out_valid, bus.in_ready, busy, got, exp1);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
        bus.out_sum !== exp1[OW-1:0]) begin
      n_fail++;
      $display("FAIL bp_release: got rdy=%b valid=%b busy=%b sum=%h want 1 0 0 %h",
               bus.in_ready, bus.out_valid, busy, bus.out_sum, exp1[OW-1:0]);
    end
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_pending_accept: got busy=%b rdy=%b want 1 0", busy, bus.in_ready);
    end
    wait_result(lat, bcnt, cins);
    got  = {bus.out_ovf, bus.out_cout, bus.out_sum};
    exp2 = exp_q.pop_front();
    n_checks++;
    if (got !== exp2 || lat !== LAT) begin
      n_fail++; $display("FAIL bp_second_result: got %h lat=%0d want %h lat=%0d", got, lat, exp2, LAT);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op;
    int lat, bcnt, seen_valid;
    logic [N-1:0]  cins;
    logic [OW+1:0] got, exp;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_a = 64'hFFFF_FFFF_FFFF_FFFF; bus.in_b = 64'h1; bus.in_cin = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (dbg_state !== 2'd0 || bus.in_ready !== 1'b1 || busy !== 1'b0 || add_cin !== 1'b0 ||
        add_a !== '0 || add_b !== '0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midop_reset: got st=%0d rdy=%b busy=%b cin=%b a=%h b=%h valid=%b want 0 1 0 0 0 0 0",
               dbg_state, bus.in_ready, busy, add_cin, add_a, add_b, bus.out_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || busy !== 1'b0) seen_valid++;
    end
    n_checks++;
    if (seen_valid !== 0) begin
      n_fail++; $display("FAIL midop_no_resume: got %0d active cycles want 0", seen_valid);
    end
    exp_q.push_back(model(64'h1, 64'h1, 1'b1));
    run_op(64'h1, 64'h1, 1'b1, lat, bcnt, cins, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp || cins !== 4'b0001) begin
      n_fail++; $display("FAIL midop_after_add: got %h cins=%b want %h cins=0001", got, cins, exp);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_carry_chain();
    test_overflow();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
